amp_envelope: RTL and testbench

- Sits directly downstream of the distance-sensor block. It consumes the 4-bit intensity level (0 = far, 8 = closest) and turns it into a smoothly ramped 8-bit gain.
- It applies that gain to the 12-bit signed audio sample stream on its way to the DAC.
- The ramp uses separate attack and release rates, so hand movement never causes zipper noise or clicks.

---
 rtl/amp_pkg.sv | 20 ++
 rtl/gain_ramp.sv | 80 ++++++++
 rtl/amp_envelope.sv | 61 ++++++
 tb/tb_amp_envelope.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/amp_pkg.sv
// rtl/amp_pkg.sv - shared types and constants for the amplitude envelope
package amp_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

  localparam int MAX_LEVEL = 8;
  localparam int GAIN_W    = 8;
  localparam int SAMPLE_W  = 12;
  localparam int PROD_W    = 21;

  localparam int DEF_TICK_DIV     = 40000;
  localparam int DEF_ATTACK_STEP  = 8;
  localparam int DEF_RELEASE_STEP = 2;
  localparam int DEF_LEVEL_SCALE  = 31;

endpackage

// File: rtl/gain_ramp.sv
// rtl/gain_ramp.sv - intensity conditioning and attack/release gain ramp
module gain_ramp
  import amp_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP,
  parameter int LEVEL_SCALE  = DEF_LEVEL_SCALE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        intensity,
  output logic [GAIN_W-1:0] gain
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [GAIN_W-1:0] ATK = GAIN_W'(ATTACK_STEP);
  localparam logic [GAIN_W-1:0] REL = GAIN_W'(RELEASE_STEP);

  logic [3:0]        sync1, sync2, sync_prev;
  logic [3:0]        level_clamped;
  logic [GAIN_W-1:0] target, gain_next;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  ramp_state_t       state, state_next;

  assign level_clamped = (sync2 > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : sync2;
  assign tick          = (cnt == CNT_W'(TICK_DIV - 1));

  // A level is only accepted once the synced value has been seen twice in a row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      target    <= '0;
    end else begin
      sync1     <= intensity;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (sync2 == sync_prev)
        target <= GAIN_W'(32'(level_clamped) * LEVEL_SCALE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      state <= HOLD;
      gain  <= '0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      state <= state_next;
      gain  <= gain_next;
    end
  end

  // Direction follows the current gain every cycle; steps are guarded so a
  // reversal can never push the gain past the target.
  always_comb begin
    state_next = HOLD;
    gain_next  = gain;
    if (target > gain)
      state_next = UP;
    else if (target < gain)
      state_next = DOWN;
    case (state)
      UP: begin
        if (tick && (target > gain))
          gain_next = ((target - gain) > ATK) ? gain + ATK : target;
      end
      DOWN: begin
        if (tick && (target < gain))
          gain_next = ((gain - target) > REL) ? gain - REL : target;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/amp_envelope.sv
// rtl/amp_envelope.sv - ramped gain applied to the audio sample stream
module amp_envelope
  import amp_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP,
  parameter int LEVEL_SCALE  = DEF_LEVEL_SCALE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          intensity,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic [GAIN_W-1:0]   gain,
  output logic                muted
);

  logic                       s1_valid;
  logic [SAMPLE_W-1:0]        s1_sample;
  logic [GAIN_W-1:0]          s1_gain;
  logic signed [PROD_W-1:0]   product;

  gain_ramp #(
    .TICK_DIV     (TICK_DIV),
    .ATTACK_STEP  (ATTACK_STEP),
    .RELEASE_STEP (RELEASE_STEP),
    .LEVEL_SCALE  (LEVEL_SCALE)
  ) u_gain_ramp (
    .clk       (clk),
    .reset     (reset),
    .intensity (intensity),
    .gain      (gain)
  );

  assign muted = (gain == '0);

  // Gain is zero-extended so the multiply stays signed; gain < 1.0 means the
  // shifted product always fits back into the sample width.
  assign product = $signed(s1_sample) * $signed({1'b0, s1_gain});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_sample  <= '0;
      s1_gain    <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_sample <= in_sample;
      s1_gain   <= gain;
      out_valid <= s1_valid;
      if (s1_valid)
        out_sample <= SAMPLE_W'(product >>> 8);
    end
  end

endmodule

// File: tb/tb_amp_envelope.sv
// tb/tb_amp_envelope.sv - self-checking bench for amp_envelope
module tb_amp_envelope;

  localparam int DIV   = 4;
  localparam int ATK   = 8;
  localparam int REL   = 2;
  localparam int SCALE = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  intensity;
  logic        in_valid;
  logic [11:0] in_sample;
  logic        out_valid;
  logic [11:0] out_sample;
  logic [7:0]  gain;
  logic        muted;

  amp_envelope #(.TICK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .intensity  (intensity),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .gain       (gain),
    .muted      (muted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: recent intensity history, target, gain, last direction,
  // tick phase and the expected output of the sample pipeline.
  int hist[3];
  int m_target, m_gain, m_dir, m_cnt;
  int m_ov, m_os, pend_v, pend_res;

  typedef struct {
    int sample;
    int expv;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = '{0, 0, 0};
    m_target = 0; m_gain = 0; m_dir = 0; m_cnt = 0;
    m_ov = 0; m_os = 0; pend_v = 0; pend_res = 0;
  endtask

  task automatic model_edge();
    int nt, ng, nd, lvl;
    nt = m_target;
    if (hist[1] == hist[2]) begin
      lvl = (hist[1] > 8) ? 8 : hist[1];
      nt  = lvl * SCALE;
    end
    ng = m_gain;
    if (m_cnt == DIV - 1) begin
      if (m_dir > 0 && m_target > m_gain)
        ng = (m_gain + ATK > m_target) ? m_target : m_gain + ATK;
      else if (m_dir < 0 && m_target < m_gain)
        ng = (m_gain - REL < m_target) ? m_target : m_gain - REL;
    end
    nd = (m_target > m_gain) ? 1 : ((m_target < m_gain) ? -1 : 0);
    m_ov = pend_v;
    if (pend_v != 0) m_os = pend_res;
    pend_v   = int'(in_valid);
    pend_res = (int'($signed(in_sample)) * m_gain) >>> 8;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = int'(intensity);
    m_target = nt; m_gain = ng; m_dir = nd; m_cnt = (m_cnt + 1) % DIV;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    @(negedge clk);
    chk("gain", int'(gain), m_gain);
    chk("muted", int'(muted), int'(m_gain == 0));
    chk("out_valid", int'(out_valid), m_ov);
    chk("out_sample", int'($signed(out_sample)), m_os);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    tbl[0] = '{2047, 1983};
    tbl[1] = '{-2048, -1984};
    tbl[2] = '{0, 0};
    tbl[3] = '{1, 0};
    tbl[4] = '{-1, -1};
    tbl[5] = '{256, 248};
    tbl[6] = '{-256, -248};
    tbl[7] = '{100, 96};
    tbl[8] = '{-100, -97};
    tbl[9] = '{1000, 968};

    reset = 1'b0; intensity = 4'd0; in_valid = 1'b0; in_sample = 12'd0;
    model_reset();
    @(negedge clk);
    chk("rst_gain", int'(gain), 0);
    chk("rst_muted", int'(muted), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    run(2);
    reset = 1'b1;

    // Attack ramp to full scale
    intensity = 4'd8;
    run(140);
    chk("ramp_top", int'(gain), 248);
    chk("ramp_top_muted", int'(muted), 0);

    // Back-to-back samples at gain 248
    for (int k = 0; k < 10; k++) begin
      in_valid  = 1'b1;
      in_sample = 12'(tbl[k].sample);
      cycle();
      if (k >= 1) begin
        chk("tbl_valid", int'(out_valid), 1);
        chk("tbl_sample", int'($signed(out_sample)), tbl[k-1].expv);
      end
    end
    in_valid = 1'b0;
    cycle();
    chk("tbl_valid_last", int'(out_valid), 1);
    chk("tbl_sample_last", int'($signed(out_sample)), tbl[9].expv);
    cycle();
    chk("tbl_drain_valid", int'(out_valid), 0);
    chk("tbl_hold_sample", int'($signed(out_sample)), tbl[9].expv);

    // Release ramp to zero, no wrap
    intensity = 4'd0;
    run(4 * 124 + 20);
    chk("release_bottom", int'(gain), 0);
    chk("release_muted", int'(muted), 1);

    // Single-cycle glitches must not disturb the target
    intensity = 4'd3;
    run(70);
    chk("glitch_settle", int'(gain), 93);
    intensity = 4'd7;
    cycle();
    intensity = 4'd3;
    for (int i = 0; i < 30; i++) begin
      cycle();
      chk("glitch_hold", int'(gain), 93);
    end

    // Clamp and mid-ramp reversal
    intensity = 4'd0;
    run(200);
    chk("clamp_start", int'(gain), 0);
    intensity = 4'd12;
    for (int i = 0; i < 100 && m_gain != 40; i++) cycle();
    chk("reach_40", int'(gain), 40);
    intensity = 4'd1;
    run(60);
    chk("down_to_31", int'(gain), 31);
    intensity = 4'd15;
    run(140);
    chk("clamp_248", int'(gain), 248);

    // Asynchronous reset mid-ramp with samples in flight
    intensity = 4'd0;
    run(12);
    in_valid = 1'b1; in_sample = 12'd1500;
    cycle();
    in_sample = 12'(-700);
    cycle();
    chk("pre_reset_valid", int'(out_valid), 1);
    reset = 1'b0;
    #1;
    chk("arst_gain", int'(gain), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_sample", int'(out_sample), 0);
    chk("arst_muted", int'(muted), 1);
    model_reset();
    in_valid = 1'b0;
    intensity = 4'd8;
    cycle();
    reset = 1'b1;
    run(30);
    chk("restart_ramp", int'(gain > 8'd0), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        intensity = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        logic [3:0] saved;
        saved = intensity;
        intensity = 4'($urandom_range(0, 15));
        cycle();
        intensity = saved;
      end
      in_valid  = 1'($urandom_range(0, 1));
      in_sample = 12'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
